// File: rtl/vram_text_writer_pkg.sv
// Shared geometry, control codes and FSM states for the text-mode VRAM writer.
package vram_text_pkg;

    localparam int COLS   = 50;
    localparam int ROWS   = 15;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = 12;

    localparam logic [7:0] DEFAULT_ATTR = 8'h0F;

    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_FF  = 8'h0C;
    localparam logic [7:0] CH_ESC = 8'h1B;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_DEL = 8'h7F;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        ESC
    } state_t;

    // Everything from space upward draws a glyph, except DEL.
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= CH_SP) && (b != CH_DEL);
    endfunction

endpackage

// File: rtl/vram_text_writer_if.sv
// Byte-stream input handshake and VRAM port-A write bus of the text writer.
interface vram_text_writer_if;
    import vram_text_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              ram_ce;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_data;

    // master: the writer itself (consumes bytes, drives the RAM port)
    modport master (
        input  in_valid, in_data,
        output in_ready, ram_ce, ram_addr, ram_data
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, ram_ce, ram_addr, ram_data
    );

endinterface

// File: rtl/vram_text_writer_cursor.sv
// Cursor position plus the linear cell address, kept incrementally so no multiplier is needed.
module text_cursor
    import vram_text_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              advance,
    input  logic              newline,
    input  logic              carriage_return,
    input  logic              backspace,
    input  logic              home,
    output logic [3:0]        row,
    output logic [5:0]        col,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] next_row_base,
    output logic              at_last_col
);

    localparam logic [5:0]        LAST_COL   = 6'(COLS - 1);
    localparam logic [3:0]        LAST_ROW   = 4'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(COLS);

    logic [ADDR_W-1:0] row_base;
    logic [3:0]        next_row;

    assign at_last_col   = (col == LAST_COL);
    assign next_row      = (row == LAST_ROW) ? 4'd0 : row + 4'd1;
    assign next_row_base = (row == LAST_ROW) ? '0 : row_base + ROW_STRIDE;
    assign addr          = row_base + ADDR_W'(col);

    // Screen wraps to row 0 instead of scrolling.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            row      <= 4'd0;
            col      <= 6'd0;
            row_base <= '0;
        end else if (home) begin
            row      <= 4'd0;
            col      <= 6'd0;
            row_base <= '0;
        end else if (newline || (advance && at_last_col)) begin
            row      <= next_row;
            col      <= 6'd0;
            row_base <= next_row_base;
        end else if (advance) begin
            col <= col + 6'd1;
        end else if (carriage_return) begin
            col <= 6'd0;
        end else if (backspace && (col != 6'd0)) begin
            col <= col - 6'd1;
        end
    end

endmodule

// File: rtl/vram_text_writer.sv
// Character-stream front end: interprets control codes and writes {attr, char} cells to VRAM port A.
module vram_text_writer
    import vram_text_pkg::*;
(
    input  logic                clk_sys,
    input  logic                reset,
    vram_text_writer_if.master  bus,
    output logic [3:0]          cursor_row,
    output logic [5:0]          cursor_col,
    output logic                busy
);

    localparam logic [9:0] ROW_LEN_M1    = 10'(COLS - 1);
    localparam logic [9:0] SCREEN_LEN_M1 = 10'(CELLS - 1);

    state_t            state, next_state;
    logic [7:0]        attr;
    logic [ADDR_W-1:0] clear_addr;
    logic [9:0]        clear_left;

    logic              accept;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_char;
    logic              op_advance, op_newline, op_cr, op_bs, op_home;
    logic              clear_start;
    logic [ADDR_W-1:0] clear_base;
    logic [9:0]        clear_len_m1;
    logic              attr_load;

    logic [ADDR_W-1:0] cur_addr, next_row_base;
    logic              at_last_col;

    text_cursor u_cursor (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .advance         (op_advance),
        .newline         (op_newline),
        .carriage_return (op_cr),
        .backspace       (op_bs),
        .home            (op_home),
        .row             (cursor_row),
        .col             (cursor_col),
        .addr            (cur_addr),
        .next_row_base   (next_row_base),
        .at_last_col     (at_last_col)
    );

    assign bus.in_ready = ((state == IDLE) || (state == ESC)) && !reset;
    assign accept       = bus.in_valid && bus.in_ready;
    assign busy         = (state == CLEAR);

    always_ff @(posedge clk_sys) begin
        if (reset) state <= CLEAR;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        wr_en        = 1'b0;
        wr_addr      = cur_addr;
        wr_char      = CH_SP;
        op_advance   = 1'b0;
        op_newline   = 1'b0;
        op_cr        = 1'b0;
        op_bs        = 1'b0;
        op_home      = 1'b0;
        clear_start  = 1'b0;
        clear_base   = '0;
        clear_len_m1 = ROW_LEN_M1;
        attr_load    = 1'b0;

        unique case (state)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clear_addr;
                if (clear_left == 10'd0) next_state = IDLE;
            end
            IDLE: begin
                if (accept) begin
                    case (bus.in_data)
                        CH_LF: begin
                            op_newline  = 1'b1;
                            clear_start = 1'b1;
                            clear_base  = next_row_base;
                            next_state  = CLEAR;
                        end
                        CH_CR: op_cr = 1'b1;
                        CH_BS: begin
                            if (cursor_col != 6'd0) begin
                                op_bs   = 1'b1;
                                wr_en   = 1'b1;
                                wr_addr = cur_addr - ADDR_W'(1);
                            end
                        end
                        CH_FF: begin
                            op_home      = 1'b1;
                            clear_start  = 1'b1;
                            clear_len_m1 = SCREEN_LEN_M1;
                            next_state   = CLEAR;
                        end
                        CH_ESC: next_state = ESC;
                        default: begin
                            if (is_printable(bus.in_data)) begin
                                wr_en      = 1'b1;
                                wr_char    = bus.in_data;
                                op_advance = 1'b1;
                                // Wrapping onto a new row blanks that row right after the glyph.
                                if (at_last_col) begin
                                    clear_start = 1'b1;
                                    clear_base  = next_row_base;
                                    next_state  = CLEAR;
                                end
                            end
                        end
                    endcase
                end
            end
            ESC: begin
                if (accept) begin
                    attr_load  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = CLEAR;
        endcase
    end

    // Attribute cannot change mid-clear because no bytes are accepted then.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            attr       <= DEFAULT_ATTR;
            clear_addr <= '0;
            clear_left <= SCREEN_LEN_M1;
        end else begin
            if (attr_load) attr <= bus.in_data;
            if (clear_start) begin
                clear_addr <= clear_base;
                clear_left <= clear_len_m1;
            end else if (state == CLEAR) begin
                clear_addr <= clear_addr + ADDR_W'(1);
                clear_left <= clear_left - 10'd1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bus.ram_ce   <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_data <= 16'h0000;
        end else begin
            bus.ram_ce <= wr_en;
            if (wr_en) begin
                bus.ram_addr <= wr_addr;
                bus.ram_data <= {attr, wr_char};
            end
        end
    end

endmodule

// File: tb/tb_vram_text_writer.sv
// Self-checking bench for vram_text_writer: vector table plus multi-cycle clear sequences, writes scoreboarded.
module tb_vram_text_writer;
    import vram_text_pkg::*;

    typedef struct {
        logic [7:0]  data;
        logic        we;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic [3:0]  row;
        logic [5:0]  col;
    } vec_t;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] data;
    } wr_t;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic [3:0] cursor_row;
    logic [5:0] cursor_col;
    logic       busy;

    vram_text_writer_if bus();

    vram_text_writer dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .bus        (bus),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    wr_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[20];

    // Every RAM write is matched in order against the expected-write queue.
    always @(negedge clk_sys) begin
        wr_t e;
        if (bus.ram_ce === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, expected no write",
                         bus.ram_addr, bus.ram_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.ram_addr !== e.addr || bus.ram_data !== e.data) begin
                    errors++;
                    $display("[TB] FAIL write: got addr=%0d data=%h, want addr=%0d data=%h",
                             bus.ram_addr, bus.ram_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic push_write(input int addr, input logic [15:0] data);
        wr_t w;
        w.addr = 12'(addr);
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic push_clear(input int base, input int n, input logic [7:0] a);
        for (int i = 0; i < n; i++) push_write(base + i, {a, 8'h20});
    endtask

    // Offers one byte and returns #1 after the edge that accepted it.
    task automatic apply_stimulus(input logic [7:0] b);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && waited < 2000) begin
            @(posedge clk_sys); #1;
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout: byte %h not accepted after %0d cycles", b, waited);
        end else begin
            @(posedge clk_sys); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 2000) begin
            @(posedge clk_sys); #1;
            n++;
        end
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic we, input int addr,
                                input logic [15:0] wd, input int row, input int col);
        vec_t v;
        v.data = d; v.we = we; v.addr = 12'(addr); v.wdata = wd;
        v.row = 4'(row); v.col = 6'(col);
        return v;
    endfunction

    initial begin
        int n;

        vecs[0]  = mk(8'h41, 1, 0, 16'h0F41, 0, 1);
        vecs[1]  = mk(8'h42, 1, 1, 16'h0F42, 0, 2);
        vecs[2]  = mk(8'h08, 1, 1, 16'h0F20, 0, 1);
        vecs[3]  = mk(8'h08, 1, 0, 16'h0F20, 0, 0);
        vecs[4]  = mk(8'h08, 0, 0, 16'h0000, 0, 0);
        vecs[5]  = mk(8'h07, 0, 0, 16'h0000, 0, 0);
        vecs[6]  = mk(8'h7F, 0, 0, 16'h0000, 0, 0);
        vecs[7]  = mk(8'h1B, 0, 0, 16'h0000, 0, 0);
        vecs[8]  = mk(8'h1E, 0, 0, 16'h0000, 0, 0);
        vecs[9]  = mk(8'h58, 1, 0, 16'h1E58, 0, 1);
        vecs[10] = mk(8'h1B, 0, 0, 16'h0000, 0, 1);
        vecs[11] = mk(8'h0F, 0, 0, 16'h0000, 0, 1);
        vecs[12] = mk(8'h80, 1, 1, 16'h0F80, 0, 2);
        vecs[13] = mk(8'h63, 1, 2, 16'h0F63, 0, 3);
        vecs[14] = mk(8'h64, 1, 3, 16'h0F64, 0, 4);
        vecs[15] = mk(8'h65, 1, 4, 16'h0F65, 0, 5);
        vecs[16] = mk(8'h66, 1, 5, 16'h0F66, 0, 6);
        vecs[17] = mk(8'h67, 1, 6, 16'h0F67, 0, 7);
        vecs[18] = mk(8'h0D, 0, 0, 16'h0000, 0, 0);
        vecs[19] = mk(8'h00, 0, 0, 16'h0000, 0, 0);

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state and power-up screen clear.
        repeat (3) @(posedge clk_sys);
        #1;
        check_output("reset_ram_ce", bus.ram_ce, 0);
        check_output("reset_ram_addr", bus.ram_addr, 0);
        check_output("reset_ram_data", bus.ram_data, 0);
        check_output("reset_busy", busy, 1);
        check_output("reset_in_ready", bus.in_ready, 0);
        check_output("reset_cursor", {cursor_row, cursor_col}, 0);
        push_clear(0, CELLS, 8'h0F);
        reset = 1'b0;
        wait_ready(n);
        check_output("powerup_ready_latency", n, 750);
        check_output("idle_busy", busy, 0);

        // Vector table: single bytes, back to back, no clears.
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].we) push_write(vecs[i].addr, vecs[i].wdata);
            apply_stimulus(vecs[i].data);
            check_output($sformatf("vec%0d_ce", i), bus.ram_ce, vecs[i].we);
            if (vecs[i].we)
                check_output($sformatf("vec%0d_addr_data", i), {bus.ram_addr, bus.ram_data},
                             {vecs[i].addr, vecs[i].wdata});
            check_output($sformatf("vec%0d_cursor", i), {cursor_row, cursor_col},
                         {vecs[i].row, vecs[i].col});
        end

        // Fifty glyphs fill row 0, the wrap blanks row 1.
        for (int i = 0; i < 50; i++) begin
            push_write(i, 16'h0F5A);
            if (i == 49) push_clear(50, 50, 8'h0F);
            apply_stimulus(8'h5A);
        end
        check_output("wrap_last_addr", bus.ram_addr, 49);
        check_output("wrap_busy", busy, 1);
        check_output("wrap_in_ready", bus.in_ready, 0);
        check_output("wrap_cursor", {cursor_row, cursor_col}, {4'd1, 6'd0});
        wait_ready(n);
        check_output("row_clear_len", n, 50);
        push_write(50, 16'h0F51);
        apply_stimulus(8'h51);
        check_output("after_wrap_cursor", {cursor_row, cursor_col}, {4'd1, 6'd1});

        // Line feeds down to row 14, then LF wraps to row 0.
        for (int r = 2; r < 15; r++) begin
            push_clear(r * 50, 50, 8'h0F);
            apply_stimulus(CH_LF);
            wait_ready(n);
        end
        check_output("row14_cursor", {cursor_row, cursor_col}, {4'd14, 6'd0});
        push_write(700, 16'h0F61);
        push_write(701, 16'h0F62);
        push_write(702, 16'h0F63);
        apply_stimulus(8'h61);
        apply_stimulus(8'h62);
        apply_stimulus(8'h63);
        check_output("row14_col3_cursor", {cursor_row, cursor_col}, {4'd14, 6'd3});
        push_clear(0, 50, 8'h0F);
        apply_stimulus(CH_LF);
        check_output("lf_wrap_cursor", {cursor_row, cursor_col}, 0);
        wait_ready(n);
        check_output("lf_wrap_clear_len", n, 50);

        // Form feed with a new attribute clears the whole screen in that attribute.
        push_write(0, 16'h0F6B);
        apply_stimulus(8'h6B);
        apply_stimulus(CH_ESC);
        apply_stimulus(8'h3C);
        push_clear(0, CELLS, 8'h3C);
        apply_stimulus(CH_FF);
        check_output("ff_cursor", {cursor_row, cursor_col}, 0);
        check_output("ff_busy", busy, 1);
        wait_ready(n);
        check_output("ff_clear_len", n, 750);

        // Reset in the middle of a row clear restarts the full default-attribute clear.
        push_clear(50, 50, 8'h3C);
        apply_stimulus(CH_LF);
        repeat (10) @(posedge clk_sys);
        #1;
        check_output("mid_clear_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk_sys); #1;
        exp_q.delete();
        check_output("abort_ram_ce", bus.ram_ce, 0);
        check_output("abort_in_ready", bus.in_ready, 0);
        check_output("abort_cursor", {cursor_row, cursor_col}, 0);
        @(posedge clk_sys); #1;
        push_clear(0, CELLS, 8'h0F);
        reset = 1'b0;
        wait_ready(n);
        check_output("restart_ready_latency", n, 750);
        push_write(0, 16'h0F4D);
        apply_stimulus(8'h4D);
        check_output("restart_attr_write", {bus.ram_addr, bus.ram_data}, {12'd0, 16'h0F4D});

        repeat (5) @(posedge clk_sys);
        #1;
        check_output("pending_writes", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
